ps2_keyboard_decoder: RTL and testbench
=======================================

# ps2_keyboard_decoder

Receives PS/2 keyboard frames and turns the scancode stream into the held-key `key_code` that the sprite-movement logic consumes. It sits between the board's PS/2 pins and sprite control. It synchronizes the keyboard clock and data lines, deframes 11-bit packets and checks parity. It then interprets the E0 (extended) and F0 (break) prefixes, so `key_code` holds the last pressed key and returns to 0 when that key is released.

## Interface
- `TIMEOUT_CYCLES`, default 100000: system-clock cycles without a PS/2 falling edge before a partial frame is abandoned (2 ms at 50 MHz).
- `clk` input 1: system clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `ps2_clk` input 1: raw keyboard clock, asynchronous to `clk`.
- `ps2_data` input 1: raw keyboard data, asynchronous to `clk`.
- `key_code` output 8: scancode of the currently held key; 8'h00 when none is held.
- `key_extended` output 1: 1 when the held key was E0-prefixed (arrow keys: up 75, down 72, left 6B, right 74).
- `make_pulse` output 1: one-cycle strobe when a make code updates `key_code`.
- `break_pulse` output 1: one-cycle strobe on every completed break sequence.
- `frame_error` output 1: one-cycle strobe on a parity error, stop-bit error or timeout.

## Operation
- Synchronizer: `ps2_clk` and `ps2_data` each pass through 2 flops giving `clk_s` and `data_s`. One more flop holds `clk_d`, the previous `clk_s`.
  - Falling edge = `clk_d`=1 and `clk_s`=0. `data_s` is sampled in that same cycle.
- Frame: start bit 0, then 8 data bits LSB first, then odd parity, then stop bit 1. Odd parity means the 8 data bits plus the parity bit contain an odd number of 1s.
- FSM states: IDLE, DATA, PARITY, STOP. A 3-bit counter indexes the data bits.
  - IDLE: on an edge with data=0 go to DATA with counter=0. On an edge with data=1 stay in IDLE with no error (treated as a glitch).
  - DATA: shift in the bit. After the 8th bit go to PARITY.
  - PARITY: latch the parity bit, then go to STOP.
  - STOP: go to IDLE. The byte is accepted only if parity is odd and the stop bit is 1. Otherwise pulse `frame_error`, discard the byte and clear both prefix flags.
- Timeout counter: cleared on every falling edge and while in IDLE; increments otherwise.
  - If it reaches `TIMEOUT_CYCLES`-1 outside IDLE: return to IDLE, pulse `frame_error` and clear the prefix flags.
- Accepted byte handling:
  - E0 sets `ext_flag`. F0 sets `brk_flag`. Neither changes any output.
  - Any other byte with `brk_flag`=0 is a make code:
    - `key_code` takes the byte and `key_extended` takes `ext_flag`.
    - `make_pulse` is asserted, including for typematic repeats of the same code.
    - Last key wins: a new make replaces the held code.
  - Any other byte with `brk_flag`=1 is a break code:
    - `break_pulse` is asserted.
    - If the byte equals `key_code` and `ext_flag` equals `key_extended`, `key_code` and `key_extended` are cleared to 0. Otherwise both are unchanged.
  - Both flags clear after any non-prefix byte.
- Reset values: `key_code`=8'h00, `key_extended`=0, all pulses 0, FSM in IDLE, flags 0, counters 0, and the synchronizer flops set to 1 (line idle).

## Timing
- Input-to-edge latency: a `ps2_clk` fall is detected 3 `clk` cycles later (2 synchronizer flops plus the edge flop).
- `key_code`, `key_extended` and all pulses are registered. They update in the cycle after the stop-bit edge is detected.
- Pulses last exactly one `clk` cycle. At most one pulse type is asserted per cycle.
- `frame_error` from a timeout asserts in the cycle after the counter hits `TIMEOUT_CYCLES`-1.
- `reset` asserted mid-frame: the next cycle is in IDLE with all outputs at their reset values. The partial frame is dropped with no error pulse.
- A falling edge in the same cycle as the timeout threshold: the edge takes priority and the counter clears.
- PS/2 bit period (60–100 µs) is far longer than `clk`, so no back-pressure or handshake is required.

## Test plan
- Frame 0x1D (W), correct parity 1, stop 1 -> `key_code`=8'h1D, `key_extended`=0, `make_pulse` for one cycle.
- E0 75 then E0 F0 75 -> `key_code`=8'h75 and `key_extended`=1 after the first byte pair; `break_pulse`, then `key_code`=8'h00 and `key_extended`=0 after the last byte.
- Make 6B, make 74, then F0 6B -> `key_code` stays 8'h74; `break_pulse` asserts once.
- Frame 0x1C with parity bit inverted -> `frame_error` for one cycle, `key_code` unchanged. The following valid 0x1C frame -> `key_code`=8'h1C.
- 4 bits sent, then the line idles with `TIMEOUT_CYCLES`=100 -> `frame_error` after 100 cycles, FSM in IDLE. The next full frame 0x29 decodes correctly.
- `reset` pulsed during bit 5 of a frame -> all outputs 0 next cycle with no `frame_error`. A subsequent valid frame decodes correctly.

Source files
------------

// File: rtl/ps2_keyboard_decoder_if.sv
// PS/2 pins in, decoded held-key state and event strobes out.
interface ps2_keyboard_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_code;
  logic       key_extended;
  logic       make_pulse;
  logic       break_pulse;
  logic       frame_error;

  modport master (
    output ps2_clk, ps2_data,
    input  key_code, key_extended, make_pulse, break_pulse, frame_error
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output key_code, key_extended, make_pulse, break_pulse, frame_error
  );
endinterface

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard receiver: synchronizes the lines, deframes 11-bit packets,
// folds E0/F0 prefixes into a held-key code for sprite control.
module ps2_keyboard_decoder #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  ps2_keyboard_decoder_if.slave   bus
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic          clk_m, clk_s, clk_d, data_m, data_s;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          ext_flag, brk_flag;
  logic [7:0]    key_code;
  logic          key_extended, make_pulse, break_pulse, frame_error;
  logic          fall;

  assign fall = clk_d & ~clk_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_m        <= 1'b1;
      clk_s        <= 1'b1;
      clk_d        <= 1'b1;
      data_m       <= 1'b1;
      data_s       <= 1'b1;
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      to_cnt       <= '0;
      ext_flag     <= 1'b0;
      brk_flag     <= 1'b0;
      key_code     <= '0;
      key_extended <= 1'b0;
      make_pulse   <= 1'b0;
      break_pulse  <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      clk_m  <= bus.ps2_clk;
      clk_s  <= clk_m;
      clk_d  <= clk_s;
      data_m <= bus.ps2_data;
      data_s <= data_m;

      make_pulse  <= 1'b0;
      break_pulse <= 1'b0;
      frame_error <= 1'b0;

      if (fall || state == IDLE) to_cnt <= '0;
      else                       to_cnt <= to_cnt + 1'b1;

      // An edge on the threshold cycle wins over the timeout.
      if (fall) begin
        case (state)
          IDLE: if (!data_s) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_s;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (data_s && (^{shreg, par_bit})) begin
              if (shreg == 8'hE0)      ext_flag <= 1'b1;
              else if (shreg == 8'hF0) brk_flag <= 1'b1;
              else begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
                if (!brk_flag) begin
                  key_code     <= shreg;
                  key_extended <= ext_flag;
                  make_pulse   <= 1'b1;
                end else begin
                  break_pulse <= 1'b1;
                  // Only releasing the held key (same code and prefix) clears it.
                  if (shreg == key_code && ext_flag == key_extended) begin
                    key_code     <= '0;
                    key_extended <= 1'b0;
                  end
                end
              end
            end else begin
              frame_error <= 1'b1;
              ext_flag    <= 1'b0;
              brk_flag    <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && to_cnt == TO_MAX) begin
        state       <= IDLE;
        to_cnt      <= '0;
        frame_error <= 1'b1;
        ext_flag    <= 1'b0;
        brk_flag    <= 1'b0;
      end
    end
  end

  assign bus.key_code     = key_code;
  assign bus.key_extended = key_extended;
  assign bus.make_pulse   = make_pulse;
  assign bus.break_pulse  = break_pulse;
  assign bus.frame_error  = frame_error;

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Directed bench for ps2_keyboard_decoder: scancode vector table plus
// timeout and mid-frame reset sequences.
module tb_ps2_keyboard_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_keyboard_decoder_if bus();

  ps2_keyboard_decoder #(.TIMEOUT_CYCLES(100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Pulse bookkeeping, sampled on the falling clock edge.
  int make_cnt = 0, brk_cnt = 0, err_cnt = 0, pulse_bad = 0;
  logic pm = 1'b0, pb = 1'b0, pe = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.make_pulse)  make_cnt++;
      if (bus.break_pulse) brk_cnt++;
      if (bus.frame_error) err_cnt++;
      if ((int'(bus.make_pulse) + int'(bus.break_pulse) + int'(bus.frame_error)) > 1) pulse_bad++;
      if ((bus.make_pulse && pm) || (bus.break_pulse && pb) || (bus.frame_error && pe)) pulse_bad++;
    end
    pm = bus.make_pulse;
    pb = bus.break_pulse;
    pe = bus.frame_error;
  end

  typedef struct {
    logic [7:0] code;
    bit         par_inv;
    bit         stop;
    logic [7:0] exp_key;
    bit         exp_ext;
    int         dm, db, de;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic [7:0] code, input bit par_inv, input bit stop,
                      input logic [7:0] exp_key, input bit exp_ext,
                      input int dm, input int db, input int de);
    vec_t v;
    v.code = code; v.par_inv = par_inv; v.stop = stop;
    v.exp_key = exp_key; v.exp_ext = exp_ext;
    v.dm = dm; v.db = db; v.de = de;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data set up while clock high, then a 20-cycle low phase.
  task automatic send_bit(input bit b);
    @(negedge clk);
    bus.ps2_data = b;
    idle(10);
    bus.ps2_clk = 1'b0;
    idle(20);
    bus.ps2_clk = 1'b1;
    idle(10);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_inv, input bit stop);
    logic par;
    par = (~^d) ^ par_inv;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    bus.ps2_data = 1'b1;
    idle(10);
  endtask

  initial begin
    int m0, b0, e0, n;
    bit seen;

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;

    addv(8'h1D, 0, 1, 8'h1D, 0, 1, 0, 0);
    addv(8'hE0, 0, 1, 8'h1D, 0, 0, 0, 0);
    addv(8'h75, 0, 1, 8'h75, 1, 1, 0, 0);
    addv(8'hE0, 0, 1, 8'h75, 1, 0, 0, 0);
    addv(8'hF0, 0, 1, 8'h75, 1, 0, 0, 0);
    addv(8'h75, 0, 1, 8'h00, 0, 0, 1, 0);
    addv(8'h6B, 0, 1, 8'h6B, 0, 1, 0, 0);
    addv(8'h74, 0, 1, 8'h74, 0, 1, 0, 0);
    addv(8'hF0, 0, 1, 8'h74, 0, 0, 0, 0);
    addv(8'h6B, 0, 1, 8'h74, 0, 0, 1, 0);
    addv(8'h1C, 1, 1, 8'h74, 0, 0, 0, 1);
    addv(8'h1C, 0, 1, 8'h1C, 0, 1, 0, 0);
    addv(8'h1C, 0, 1, 8'h1C, 0, 1, 0, 0);
    addv(8'hF0, 0, 1, 8'h1C, 0, 0, 0, 0);
    addv(8'h22, 0, 0, 8'h1C, 0, 0, 0, 1);
    addv(8'h1C, 0, 1, 8'h1C, 0, 1, 0, 0);
    addv(8'hE0, 0, 1, 8'h1C, 0, 0, 0, 0);
    addv(8'hF0, 0, 1, 8'h1C, 0, 0, 0, 0);
    addv(8'h1C, 0, 1, 8'h1C, 0, 0, 1, 0);
    addv(8'hF0, 0, 1, 8'h1C, 0, 0, 0, 0);
    addv(8'h1C, 0, 1, 8'h00, 0, 0, 1, 0);
    addv(8'h1C, 0, 1, 8'h1C, 0, 1, 0, 0);

    idle(4);
    chk("rst_key", bus.key_code, 8'h00);
    chk("rst_ext", bus.key_extended, 0);
    chk("rst_pulses", {bus.make_pulse, bus.break_pulse, bus.frame_error}, 0);
    reset = 1'b0;
    idle(20);

    foreach (vecs[i]) begin
      m0 = make_cnt; b0 = brk_cnt; e0 = err_cnt;
      send_frame(vecs[i].code, vecs[i].par_inv, vecs[i].stop);
      chk($sformatf("v%0d_key", i), bus.key_code, vecs[i].exp_key);
      chk($sformatf("v%0d_ext", i), bus.key_extended, vecs[i].exp_ext);
      chk($sformatf("v%0d_pulses", i),
          ((make_cnt - m0) << 8) | ((brk_cnt - b0) << 4) | (err_cnt - e0),
          (vecs[i].dm << 8) | (vecs[i].db << 4) | vecs[i].de);
    end

    // Partial frame (start + 3 data bits), then the line idles.
    e0 = err_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    bus.ps2_data = 1'b1;
    idle(10);
    bus.ps2_clk = 1'b0;
    n = 0;
    seen = 0;
    idle(20);
    bus.ps2_clk = 1'b1;
    n = 20;
    while (n < 400 && !seen) begin
      @(negedge clk);
      n++;
      if (bus.frame_error) seen = 1;
    end
    chk("timeout_seen", int'(seen), 1);
    chk("timeout_latency_ok", int'(n >= 101 && n <= 105), 1);
    chk("timeout_key_kept", bus.key_code, 8'h1C);
    idle(20);
    chk("timeout_one_err", err_cnt - e0, 1);
    send_frame(8'h29, 0, 1);
    chk("after_to_key", bus.key_code, 8'h29);
    chk("after_to_ext", bus.key_extended, 0);

    // Reset while bit 5 is on the wire (clock still high).
    e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    @(negedge clk);
    bus.ps2_data = 1'b0;
    idle(5);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_key", bus.key_code, 8'h00);
    chk("midrst_ext", bus.key_extended, 0);
    chk("midrst_pulses", {bus.make_pulse, bus.break_pulse, bus.frame_error}, 0);
    reset = 1'b0;
    bus.ps2_data = 1'b1;
    idle(200);
    chk("midrst_no_err", err_cnt - e0, 0);
    m0 = make_cnt;
    send_frame(8'h29, 0, 1);
    chk("after_rst_key", bus.key_code, 8'h29);
    chk("after_rst_make", make_cnt - m0, 1);

    chk("pulse_shape", pulse_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
